// File: rtl/video_stream_pack.sv
// video_stream_pack
// Re-times the decoded OV5640 pixel stream (vs/hs/de/rgb) into an AXI4-Stream
// video master (tuser = start of frame, tlast = end of line) through a small
// first-word-fall-through FIFO. A FIFO overflow drops the rest of the frame and
// the block resynchronises at the next frame start.
//
// Optional feature: define VSP_STATS_EN to build the frame/line/pixel
// statistics counters. Without it frame_cnt_o, line_len_o and line_cnt_o are
// tied to zero; streaming and overflow behaviour are identical.

module video_stream_pack #(
  parameter int FIFO_AW = 4
) (
  input  logic        cmos_pclk_i,
  input  logic        rst_i,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] rgb_i,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        ovf_clr_i,
  output logic        overflow_o,
  output logic [15:0] frame_cnt_o,
  output logic [11:0] line_len_o,
  output logic [11:0] line_cnt_o
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int WORD_W = 26;  // {tuser, tlast, data[23:0]}

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DROP
  } state_t;

  state_t state, state_nxt;

  // Sync edge detection
  logic vs_d, hs_d;
  logic vs_rise, vs_fall, hs_fall, pix_valid;

  // One-pixel hold stage (tlast is only known once the line has ended)
  logic        hold_v;
  logic        hold_user;
  logic [23:0] hold_data;
  logic        sof_pend;

  // Push control
  logic accept;
  logic push_req;
  logic push_last;
  logic push_ok;
  logic ovf_set;

  // FIFO
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, pop;
  logic [WORD_W-1:0]  rd_word;

  // Delay vs/hs by one cycle for edge detection.
  // NOTE: these delay flops are deliberately left out of reset: they keep
  // tracking the pins during reset, so releasing reset in the middle of a frame
  // cannot be mistaken for a vs rising edge.
  always_ff @(posedge cmos_pclk_i) begin
    vs_d <= vs_i;
    hs_d <= hs_i;
  end

  assign vs_rise   = vs_i & ~vs_d;
  assign vs_fall   = ~vs_i & vs_d;
  assign hs_fall   = ~hs_i & hs_d;
  assign pix_valid = vs_i & hs_i & de_i;

  assign full  = count[FIFO_AW];  // count never exceeds DEPTH
  assign empty = (count == '0);
  assign pop   = m_axis_tvalid & m_axis_tready;

  // Frame state register.
  always_ff @(posedge cmos_pclk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, pixel acceptance and FIFO push requests.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    push_req  = 1'b0;
    push_last = 1'b0;
    ovf_set   = 1'b0;

    case (state)
      IDLE:    if (vs_rise) state_nxt = ACTIVE;
      ACTIVE: begin
        accept = pix_valid;
        if (vs_fall) state_nxt = IDLE;
      end
      DROP:    if (vs_rise) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase

    // A new pixel pushes the held one as a mid-line beat; a line or frame end
    // pushes it as the last beat of the line.
    if (hold_v) begin
      if (accept) begin
        push_req = 1'b1;
      end else if (hs_fall | vs_fall) begin
        push_req  = 1'b1;
        push_last = 1'b1;
      end
    end

    // A push into a full FIFO is refused even if a pop happens on this edge.
    ovf_set = push_req & full;
    if (ovf_set) state_nxt = DROP;
  end

  assign push_ok = push_req & ~full;

  // Hold register and pending start-of-frame flag.
  // NOTE: sequential state is only ever updated with non-blocking assignments
  // so every flop samples the pre-edge values of its peers.
  always_ff @(posedge cmos_pclk_i) begin
    if (rst_i) begin
      hold_v    <= 1'b0;
      hold_user <= 1'b0;
      hold_data <= '0;
      sof_pend  <= 1'b0;
    end else begin
      if (vs_rise & ~ovf_set)     sof_pend <= 1'b1;
      else if (accept & ~ovf_set) sof_pend <= 1'b0;

      if (ovf_set | vs_rise) begin
        // Overflow drops the held pixel; a new frame start discards a
        // pixel whose line never ended.
        hold_v <= 1'b0;
      end else if (accept) begin
        hold_v    <= 1'b1;
        hold_data <= rgb_i;
        hold_user <= sof_pend;
      end else if (push_req) begin
        hold_v <= 1'b0;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; only pointers and count are reset,
  // and the outputs are masked while the FIFO is empty.
  always_ff @(posedge cmos_pclk_i) begin
    if (push_ok) mem[wr_ptr] <= {hold_user, push_last, hold_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge cmos_pclk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // First-word-fall-through read side.
  assign rd_word       = mem[rd_ptr];
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0   : rd_word[23:0];
  assign m_axis_tlast  = empty ? 1'b0 : rd_word[24];
  assign m_axis_tuser  = empty ? 1'b0 : rd_word[25];

  // Sticky overflow flag; a new overflow wins over a clear on the same edge.
  always_ff @(posedge cmos_pclk_i) begin
    if (rst_i)          overflow_o <= 1'b0;
    else if (ovf_set)   overflow_o <= 1'b1;
    else if (ovf_clr_i) overflow_o <= 1'b0;
  end

`ifdef VSP_STATS_EN
  logic [11:0] pix_cnt;
  logic [11:0] line_acc, line_acc_nxt;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Line count of the current frame, including an hs_fall on this edge.
  always_comb begin
    line_acc_nxt = line_acc;
    if (vs_rise)                         line_acc_nxt = '0;
    else if (hs_fall && state == ACTIVE) line_acc_nxt = sat_inc(line_acc);
  end

  // Pixel, line and frame statistics.
  always_ff @(posedge cmos_pclk_i) begin
    if (rst_i) begin
      pix_cnt     <= '0;
      line_acc    <= '0;
      line_len_o  <= '0;
      line_cnt_o  <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (hs_fall) begin
        line_len_o <= pix_cnt;
        pix_cnt    <= '0;
      end else if (accept) begin
        pix_cnt <= sat_inc(pix_cnt);
      end

      line_acc <= line_acc_nxt;
      if (vs_fall) line_cnt_o <= line_acc_nxt;

      if (vs_rise) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`else
  assign frame_cnt_o = '0;
  assign line_len_o  = '0;
  assign line_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_video_stream_pack.sv
// Self-checking bench for video_stream_pack: directed test-plan scenarios plus
// randomized frames, all compared every cycle against a queue-based model.

module tb_video_stream_pack;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef VSP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_i, vs_i, hs_i, de_i, ovf_clr_i, m_axis_tready;
  logic [23:0] rgb_i;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow_o;
  logic [15:0] frame_cnt_o;
  logic [11:0] line_len_o, line_cnt_o;

  video_stream_pack #(.FIFO_AW(AW)) dut (
    .cmos_pclk_i  (clk),
    .rst_i        (rst_i),
    .vs_i         (vs_i),
    .hs_i         (hs_i),
    .de_i         (de_i),
    .rgb_i        (rgb_i),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .ovf_clr_i    (ovf_clr_i),
    .overflow_o   (overflow_o),
    .frame_cnt_o  (frame_cnt_o),
    .line_len_o   (line_len_o),
    .line_cnt_o   (line_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ACT, M_DROP} mstate_t;
  logic [25:0] mq[$];          // expected FIFO contents {tuser,tlast,data}
  mstate_t     m_state = M_IDLE;
  bit          pvs = 0, phs = 0;
  bit          pend_v = 0, pend_u = 0, sof = 0, ovf = 0;
  logic [23:0] pend_d = '0;
  int          pix = 0, lines = 0, llen = 0, lcnt = 0;
  logic [15:0] fcnt = '0;

  task automatic model_update(input bit vs, input bit hs, input bit de,
                              input logic [23:0] rgb, input bit rdy,
                              input bit rst, input bit clr);
    bit vr, vf, hf, acc, push, refused, pop;
    logic [25:0] b;
    int lnext;
    vr = vs & ~pvs;
    vf = ~vs & pvs;
    hf = ~hs & phs;
    pvs = vs;
    phs = hs;
    if (rst) begin
      mq.delete();
      m_state = M_IDLE;
      pend_v = 0; sof = 0; ovf = 0;
      pix = 0; lines = 0; llen = 0; lcnt = 0; fcnt = '0;
      return;
    end
    pop     = (mq.size() != 0) && rdy;
    acc     = (m_state == M_ACT) && vs && hs && de;
    push    = pend_v && (acc || hf || vf);
    b       = {pend_u, ~acc, pend_d};
    refused = push && (mq.size() == DEPTH);

    // statistics
    if (hf) begin
      llen = pix;
      pix  = 0;
    end else if (acc && pix < 4095) begin
      pix++;
    end
    if (vr) lnext = 0;
    else if (hf && m_state == M_ACT) lnext = (lines < 4095) ? lines + 1 : lines;
    else lnext = lines;
    if (vf) lcnt = lnext;
    lines = lnext;
    if (vr) fcnt = fcnt + 16'd1;

    // FIFO
    if (pop) void'(mq.pop_front());
    if (push && !refused) mq.push_back(b);

    // hold stage
    if (refused || vr) pend_v = 0;
    else if (acc) begin
      pend_v = 1;
      pend_d = rgb;
      pend_u = sof;
    end else if (push) pend_v = 0;
    if (vr && !refused) sof = 1;
    else if (acc && !refused) sof = 0;

    if (refused) ovf = 1;
    else if (clr) ovf = 0;

    if (refused) m_state = M_DROP;
    else begin
      case (m_state)
        M_IDLE:  if (vr) m_state = M_ACT;
        M_ACT:   if (vf) m_state = M_IDLE;
        default: if (vr) m_state = M_ACT;
      endcase
    end
  endtask

  task automatic compare_outputs();
    check("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("tdata", 32'(m_axis_tdata), 32'(mq[0][23:0]));
      check("tuser", 32'(m_axis_tuser), 32'(mq[0][25]));
      check("tlast", 32'(m_axis_tlast), 32'(mq[0][24]));
    end
    check("overflow",  32'(overflow_o),  32'(ovf));
    check("frame_cnt", 32'(frame_cnt_o), STATS ? 32'(fcnt) : 32'd0);
    check("line_len",  32'(line_len_o),  STATS ? 32'(llen) : 32'd0);
    check("line_cnt",  32'(line_cnt_o),  STATS ? 32'(lcnt) : 32'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  int          rmode = 0;    // 0 ready, 1 toggle, 2 random, 3 stalled
  bit          tog   = 1;
  logic [25:0] cap[$];       // observed handshaken beats
  logic [23:0] sent_q[$];    // pixels driven with vs&hs&de
  bit          stall_prev = 0;
  logic [25:0] stall_word;

  // One clock: drive inputs at negedge, advance model, compare at next negedge.
  task automatic step(input bit vs, input bit hs, input bit de,
                      input logic [23:0] rgb, input bit rst = 1'b0,
                      input bit clr = 1'b0);
    bit rdy;
    if (stall_prev)
      check("stable", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(stall_word));
    case (rmode)
      0:       rdy = 1'b1;
      1:       begin rdy = tog; tog = ~tog; end
      2:       rdy = ($urandom_range(0, 2) != 0);
      default: rdy = 1'b0;
    endcase
    vs_i = vs; hs_i = hs; de_i = de; rgb_i = rgb;
    rst_i = rst; ovf_clr_i = clr; m_axis_tready = rdy;
    if (!rst && m_axis_tvalid && rdy)
      cap.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    stall_prev = !rst && m_axis_tvalid && !rdy;
    stall_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    model_update(vs, hs, de, rgb, rdy, rst, clr);
    @(negedge clk);
    compare_outputs();
  endtask

  // gap: 0 = de every cycle, 1 = every 2nd cycle, 2 = random
  task automatic send_frame(input int w, input int h, input int gap);
    logic [23:0] px;
    bit ph;
    repeat (2) step(0, 0, 0, '0);
    repeat (2) step(1, 0, 0, '0);
    for (int l = 0; l < h; l++) begin
      int sent = 0;
      ph = 1;
      while (sent < w) begin
        bit de;
        de = (gap == 0) ? 1'b1 : (gap == 1) ? ph : 1'($urandom_range(0, 1));
        ph = ~ph;
        px = 24'($urandom());
        step(1, 1, de, px);
        if (de) begin
          sent++;
          sent_q.push_back(px);
        end
      end
      repeat (2) step(1, 0, 0, '0);
    end
    step(0, 0, 0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() != 0 && n < 300) begin
      step(0, 0, 0, '0);
      n++;
    end
    check("drain_bound", 32'(mq.size()), 32'd0);
    repeat (2) step(0, 0, 0, '0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    rst_i = 1; vs_i = 0; hs_i = 0; de_i = 0; rgb_i = '0;
    ovf_clr_i = 0; m_axis_tready = 0;
    @(negedge clk);

    // Reset state
    repeat (3) step(0, 0, 0, '0, 1'b1);
    check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",    32'(m_axis_tdata),  32'd0);
    check("rst_overflow", 32'(overflow_o),    32'd0);
    check("rst_frame",    32'(frame_cnt_o),   32'd0);
    check("rst_line_len", 32'(line_len_o),    32'd0);

    // Pixels on hs before any vs_rise are ignored
    rmode = 0;
    repeat (6) step(0, 1, 1, 24'($urandom()));
    step(0, 0, 0, '0);
    check("prevs_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("prevs_frame",  32'(frame_cnt_o),   32'd0);

    // 4x3 frame, always ready
    cap.delete(); sent_q.delete();
    send_frame(4, 3, 0);
    drain();
    check("f43_beats", 32'(cap.size()), 32'd12);
    for (int i = 0; i < cap.size() && i < 12; i++) begin
      check("f43_data", 32'(cap[i][23:0]), 32'(sent_q[i]));
      check("f43_tuser", 32'(cap[i][25]), 32'(i == 0));
      check("f43_tlast", 32'(cap[i][24]), 32'(i % 4 == 3));
    end
    check("f43_line_len",  32'(line_len_o),  STATS ? 32'd4 : 32'd0);
    check("f43_line_cnt",  32'(line_cnt_o),  STATS ? 32'd3 : 32'd0);
    check("f43_frame_cnt", 32'(frame_cnt_o), STATS ? 32'd1 : 32'd0);

    // Overflow: sink stalled, one 20-pixel line
    rmode = 3;
    repeat (2) step(0, 0, 0, '0);
    repeat (2) step(1, 0, 0, '0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 1, 24'($urandom()));
      if (i == 17) check("ovf_before18", 32'(overflow_o), 32'd0);
      if (i == 18) check("ovf_at18",     32'(overflow_o), 32'd1);
    end
    repeat (2) step(1, 0, 0, '0);
    repeat (2) step(0, 0, 0, '0);
    rmode = 0;
    cap.delete();
    drain();
    check("ovf_beats", 32'(cap.size()), 32'd16);
    nl = 0;
    foreach (cap[i]) nl += int'(cap[i][24]);
    check("ovf_no_tlast", 32'(nl), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    cap.delete(); sent_q.delete();
    send_frame(4, 3, 0);
    drain();
    check("post_ovf_beats", 32'(cap.size()), 32'd12);
    if (cap.size() > 0) check("post_ovf_tuser", 32'(cap[0][25]), 32'd1);
    step(0, 0, 0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow_o), 32'd0);

    // 3x2 frame with tready toggling
    rmode = 1; tog = 1;
    cap.delete(); sent_q.delete();
    send_frame(3, 2, 0);
    drain();
    check("tog_beats", 32'(cap.size()), 32'd6);
    for (int i = 0; i < cap.size() && i < 6; i++)
      check("tog_data", 32'(cap[i][23:0]), 32'(sent_q[i]));
    check("tog_overflow", 32'(overflow_o), 32'd0);

    // vs falls while hs is still high after 5 pixels
    rmode = 0;
    cap.delete();
    repeat (2) step(0, 0, 0, '0);
    repeat (2) step(1, 0, 0, '0);
    repeat (5) step(1, 1, 1, 24'($urandom()));
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    drain();
    check("vsfall_beats", 32'(cap.size()), 32'd5);
    if (cap.size() == 5) begin
      check("vsfall_tlast4", 32'(cap[4][24]), 32'd1);
      check("vsfall_tlast3", 32'(cap[3][24]), 32'd0);
    end
    repeat (3) step(0, 1, 1, 24'($urandom()));  // must stay idle
    check("vsfall_idle", 32'(m_axis_tvalid), 32'd0);

    // Reset during line 2, then a clean frame
    repeat (2) step(0, 0, 0, '0);
    repeat (2) step(1, 0, 0, '0);
    repeat (4) step(1, 1, 1, 24'($urandom()));
    repeat (2) step(1, 0, 0, '0);
    repeat (2) step(1, 1, 1, 24'($urandom()));
    step(1, 1, 1, 24'($urandom()), 1'b1);
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_frame",  32'(frame_cnt_o),   32'd0);
    check("midrst_len",    32'(line_len_o),    32'd0);
    repeat (2) step(1, 1, 1, 24'($urandom()));
    repeat (2) step(1, 0, 0, '0);
    repeat (4) step(1, 1, 1, 24'($urandom()));
    step(0, 0, 0, '0);
    check("midrst_quiet", 32'(m_axis_tvalid), 32'd0);
    cap.delete(); sent_q.delete();
    send_frame(4, 3, 0);
    drain();
    check("rst_frame_beats", 32'(cap.size()), 32'd12);
    if (cap.size() > 0) check("rst_frame_tuser", 32'(cap[0][25]), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt_o), STATS ? 32'd1 : 32'd0);

    // Randomized frames, ready patterns and overflow clears
    for (int f = 0; f < 25; f++) begin
      rmode = $urandom_range(0, 2);
      send_frame($urandom_range(1, 24), $urandom_range(1, 4), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, '0, 1'b0, 1'b1);
    end
    rmode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
